// File: rtl/mempool_tile_resp_age_arbiter.sv
// Age-ordered N-to-M response arbiter: grants up to NumOut valid inputs per cycle, oldest first.
// Define MEMPOOL_RESP_ARB_STATS_EN to build the grant/stall/max-age statistics outputs.
module mempool_tile_resp_age_arbiter #(
  parameter int unsigned NumInp    = 16,
  parameter int unsigned NumOut    = 3,
  parameter int unsigned AgeWidth  = 4,
  parameter bit          OutReg    = 1'b1,
  parameter type         payload_t = logic
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  payload_t [NumInp-1:0] data_i,
  input  logic [NumInp-1:0]     valid_i,
  output logic [NumInp-1:0]     ready_o,
  output payload_t [NumOut-1:0] data_o,
  output logic [NumOut-1:0]     valid_o,
  input  logic [NumOut-1:0]     ready_i,
  output logic [31:0]           grant_cnt_o,
  output logic [31:0]           stall_cnt_o,
  output logic [AgeWidth-1:0]   max_age_o
);

  localparam int unsigned IdxW = (NumInp > 1) ? $clog2(NumInp) : 1;
  localparam logic [AgeWidth-1:0] AgeMax = {AgeWidth{1'b1}};

  logic [AgeWidth-1:0] age_q [NumInp];
  logic [AgeWidth-1:0] age_d [NumInp];
  logic [NumInp-1:0]   req;
  logic [NumInp-1:0]   grant;
  logic [NumOut-1:0]   avail;
  logic [NumOut-1:0]   slot_load;
  logic [IdxW-1:0]     slot_src [NumOut];

  // Masking requests during reset keeps ready_o and any pass-through valid_o low.
  assign req     = valid_i & {NumInp{~rst_i}};
  assign ready_o = grant;

  // Rank of an input = number of requesters ahead of it (older, or equally old and lower index).
  // The input of rank r takes the r-th available slot in ascending output order.
  always_comb begin
    int unsigned rank;
    int unsigned pos;
    grant     = '0;
    slot_load = '0;
    rank      = 0;
    pos       = 0;
    for (int unsigned k = 0; k < NumOut; k++) slot_src[k] = '0;
    for (int unsigned j = 0; j < NumInp; j++) begin
      rank = 0;
      for (int unsigned i = 0; i < NumInp; i++) begin
        if (req[i] && ((age_q[i] > age_q[j]) || ((age_q[i] == age_q[j]) && (i < j)))) begin
          rank = rank + 1;
        end
      end
      pos = 0;
      for (int unsigned k = 0; k < NumOut; k++) begin
        if (avail[k]) begin
          if (req[j] && (pos == rank)) begin
            grant[j]     = 1'b1;
            slot_load[k] = 1'b1;
            slot_src[k]  = IdxW'(j);
          end
          pos = pos + 1;
        end
      end
    end
  end

  always_comb begin
    for (int unsigned j = 0; j < NumInp; j++) begin
      if (valid_i[j] && !ready_o[j]) begin
        age_d[j] = (age_q[j] == AgeMax) ? AgeMax : age_q[j] + AgeWidth'(1);
      end else begin
        age_d[j] = '0;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned j = 0; j < NumInp; j++) age_q[j] <= '0;
    end else begin
      for (int unsigned j = 0; j < NumInp; j++) age_q[j] <= age_d[j];
    end
  end

  if (OutReg) begin : gen_out_reg
    payload_t [NumOut-1:0] data_q;
    logic [NumOut-1:0]     valid_q;

    // A slot draining this cycle may be reloaded in the same cycle.
    assign avail = ~valid_q | ready_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        valid_q <= '0;
        data_q  <= '0;
      end else begin
        for (int unsigned k = 0; k < NumOut; k++) begin
          if (slot_load[k]) begin
            valid_q[k] <= 1'b1;
            data_q[k]  <= data_i[slot_src[k]];
          end else if (ready_i[k]) begin
            valid_q[k] <= 1'b0;
          end
        end
      end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
  end else begin : gen_out_comb
    assign avail   = ready_i;
    assign valid_o = slot_load;

    always_comb begin
      data_o = '0;
      for (int unsigned k = 0; k < NumOut; k++) begin
        if (slot_load[k]) data_o[k] = data_i[slot_src[k]];
      end
    end
  end

`ifdef MEMPOOL_RESP_ARB_STATS_EN
  logic [31:0]         grant_cnt_q;
  logic [31:0]         stall_cnt_q;
  logic [31:0]         hs_num;
  logic [AgeWidth-1:0] max_age;

  always_comb begin
    hs_num  = '0;
    max_age = '0;
    for (int unsigned k = 0; k < NumOut; k++) begin
      if (valid_o[k] && ready_i[k]) hs_num = hs_num + 32'd1;
    end
    for (int unsigned j = 0; j < NumInp; j++) begin
      if (age_q[j] > max_age) max_age = age_q[j];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      grant_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      grant_cnt_q <= grant_cnt_q + hs_num;
      stall_cnt_q <= stall_cnt_q + 32'(|(valid_i & ~ready_o));
    end
  end

  assign grant_cnt_o = grant_cnt_q;
  assign stall_cnt_o = stall_cnt_q;
  assign max_age_o   = max_age;
`else
  assign grant_cnt_o = '0;
  assign stall_cnt_o = '0;
  assign max_age_o   = '0;
`endif

endmodule

// File: doc/mempool_tile_resp_age_arbiter.md
# mempool_tile_resp_age_arbiter

Parametrised N-to-M response arbiter for the MemPool tile response path. It sits between the tile's bank/remote response sources and the core-side response ports. Each cycle it grants up to NumOut of NumInp valid inputs, oldest first, using per-input saturating wait counters. An optional output register makes the output streams handshake-stable.

## Interface

Parameters:
- NumInp, 16: number of input response streams.
- NumOut, 3: number of output ports; at least 1.
- AgeWidth, 4: width of the per-input wait counter; at least 1.
- OutReg, 1: 1 gives one register slot per output (1-cycle latency); 0 gives a combinational pass-through.
- payload_t, logic: response payload type.

Ports:
- clk_i  in  1  single clock; all state on rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- data_i  in  NumInp x payload_t  input payloads.
- valid_i  in  NumInp  input valid; upstream holds valid_i/data_i stable until handshake.
- ready_o  out  NumInp  input grant; combinational from valid_i, age state and output-slot state.
- data_o  out  NumOut x payload_t  output payloads.
- valid_o  out  NumOut  output valid.
- ready_i  in  NumOut  output ready.
- grant_cnt_o  out  32  total output handshakes (stats).
- stall_cnt_o  out  32  cycles with at least one valid, ungranted input (stats).
- max_age_o  out  AgeWidth  maximum current age_q (stats).

## Operation

- Per-input age_q[j]: updated as follows.
  - valid_i[j] & ~ready_o[j]: increments, saturating at 2^AgeWidth-1.
  - Otherwise (handshake or idle): cleared to 0.
- Slot availability avail[k]:
  - OutReg=1: ~valid_o[k] | ready_i[k].
  - OutReg=0: ready_i[k].
- Let A = popcount(avail). Selection:
  - Rank valid inputs by age_q descending; ties go to the lower index.
  - Grant the first min(A, popcount(valid_i)) of them.
  - The n-th ranked grant maps to the n-th available output, in ascending output index.
- ready_o[j] is 1 exactly for granted inputs. At most one output per input; at most one input per output.
- OutReg=1:
  - Slot k loads data_i of its assigned input and sets valid_o[k].
  - Otherwise, if ready_i[k], it clears valid_o[k].
  - valid_o/data_o stay stable while ~ready_i[k].
- OutReg=0:
  - valid_o[k] = slot k assigned this cycle; data_o is muxed from the assigned input.
  - Assignment may change between cycles while ready_i is low, so stability is not guaranteed.
- While rst_i is high, ready_o is forced to 0.
- Starvation bound: a waiting input reaches saturated age within 2^AgeWidth-1 cycles. Among saturated inputs the lowest index wins. Fairness is guaranteed only while wait stays below saturation.

## Timing

- Reset (async, immediate): age_q=0, valid_o=0, data_o=0, ready_o=0. Stats counters are 0.
- Latency:
  - OutReg=1: grant in cycle t, valid_o in cycle t+1.
  - OutReg=0: 0 cycles.
- Throughput: NumOut responses per cycle when all outputs are ready.
- Age update takes effect in the cycle after the wait.
- Simultaneous events:
  - A slot draining (ready_i) and reloading in the same cycle is allowed and counts as available.
  - An input granted in the cycle its age saturates clears to 0.
- NumInp <= NumOut: every valid input is granted whenever enough slots are available.
- Reset asserted mid-transfer discards slot contents. No response is replayed.

## Configuration

- MEMPOOL_RESP_ARB_STATS_EN defined:
  - grant_cnt_o increments by popcount(valid_o & ready_i) per cycle and wraps at 2^32.
  - stall_cnt_o increments by 1 per cycle when any(valid_i & ~ready_o) and wraps at 2^32.
  - max_age_o = max over j of age_q[j].
- Not defined: the three stats outputs are tied to 0 and no counter logic exists.

## Test plan

- Reset: rst_i=1 with valid_i=all ones. Required: ready_o=0 and valid_o=0. Release rst_i; the first edge grants inputs 0,1,2.
- Drain (16/3, OutReg=1, ready_i=3'b111): all 16 inputs valid, each dropping valid after its grant.
  - Grants follow index order: {0,1,2}, {3,4,5}, and so on.
  - All 16 are delivered within 6 cycles, valid_o in cycles t+1..t+6.
  - Each payload appears exactly once.
- Age priority: input 9 valid with ready_i=0 for 3 cycles (age_q[9]=3). Then inputs 0 and 1 become valid and ready_i=3'b001.
  - Input 9 is granted to output 0 first, then 0, then 1.
- Saturation (AgeWidth=2): inputs 5 and 2 stalled for 5 cycles, both at age 3. Then a single slot opens.
  - Input 2 is granted, then input 5.
- Backpressure (OutReg=1): ready_i=3'b101 with output 1 loaded with payload 0xA5.
  - valid_o[1]=1 and data_o[1]=0xA5 stay constant for 10 cycles.
  - New grants go only to outputs 0 and 2.
- Stats (macro on): 10 output handshakes, with 4 cycles where an input was left waiting.
  - grant_cnt_o=10 and stall_cnt_o=4.
  - Macro off, same stimulus: all stats outputs read 0.
